regfile_wb_arbiter: RTL and testbench

- Write-back arbiter and scoreboard for the 32x32 integer / 32x32 FP register file.
- Three producers compete for the single write slot per cycle: int ALU (req 0), FP unit (req 1), load unit (req 2).
- Each producer makes an int write, an FP single write, or an FP double (pair) write.
- Also keeps per-register pending-write busy bits that the issue stage uses for RAW/WAW stalls.

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter + busy scoreboard; define WBARB_FIXED_PRIO_EN for fixed priority (2>1>0) instead of round-robin
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [2:0]        req_is_fp,
  input  logic [2:0]        req_dbl,
  input  logic [3*AW-1:0]   req_reg,
  input  logic [3*DATA_W-1:0] req_data_lo,
  input  logic [3*DATA_W-1:0] req_data_hi,
  output logic              rf_we_i,
  output logic [AW-1:0]     rf_waddr_i,
  output logic [DATA_W-1:0] rf_wdata_i,
  output logic              rf_we_f,
  output logic              rf_dwe_f,
  output logic [AW-1:0]     rf_waddr_f,
  output logic [DATA_W-1:0] rf_wdata1_f,
  output logic [DATA_W-1:0] rf_wdata2_f,
  input  logic              alloc_valid,
  input  logic              alloc_is_fp,
  input  logic              alloc_dbl,
  input  logic [AW-1:0]     alloc_reg,
  output logic [(1<<AW)-1:0] busy_i,
  output logic [(1<<AW)-1:0] busy_f,
  output logic              err_illegal
);
  localparam int N = 1 << AW;
  localparam logic [AW-1:0] TOP = AW'(N - 1);
  logic [2:0] gnt;
  logic [1:0] gidx;
`ifdef WBARB_FIXED_PRIO_EN
  // Fixed priority: load unit, then FP unit, then int ALU
  always_comb gnt = req_valid[2] ? 3'b100 : req_valid[1] ? 3'b010 : {2'b00, req_valid[0]};
`else
  logic [1:0] ptr_q, ptr_d, s1, s2;
  assign s1 = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
  assign s2 = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
  // Round-robin: first valid producer starting at the pointer
  always_comb begin
    gnt = '0;
    if (req_valid[ptr_q]) gnt[ptr_q] = 1'b1;
    else if (req_valid[s1]) gnt[s1] = 1'b1;
    else if (req_valid[s2]) gnt[s2] = 1'b1;
  end
  assign ptr_d = gidx == 2'd2 ? 2'd0 : gidx + 2'd1;
  // Pointer moves past the granted producer, held when nobody is granted
  always_ff @(posedge clk)
    if (reset) ptr_q <= '0;
    else if (|gnt) ptr_q <= ptr_d;
`endif
  assign gidx = gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0;
  assign req_ready = gnt;
  logic              any, g_fp, g_dbl, g_nz, g_top;
  logic [AW-1:0]     g_reg;
  logic [DATA_W-1:0] g_lo, g_hi;
  assign any   = |gnt;
  assign g_fp  = req_is_fp[gidx];
  assign g_dbl = req_dbl[gidx];
  assign g_reg = req_reg[int'(gidx)*AW +: AW];
  assign g_lo  = req_data_lo[int'(gidx)*DATA_W +: DATA_W];
  assign g_hi  = req_data_hi[int'(gidx)*DATA_W +: DATA_W];
  assign g_nz  = g_reg != '0;
  assign g_top = g_reg == TOP;
  logic we_i_d, we_f_d, dwe_d, bad_w;
  assign we_i_d = any & ~g_fp & g_nz;
  assign we_f_d = any & g_fp & ~g_dbl & g_nz;
  assign dwe_d  = any & g_fp & g_dbl & g_nz & ~g_top;
  assign bad_w  = any & g_fp & g_dbl & (~g_nz | g_top);
  logic a_nz, a_bad;
  logic [N-1:0] a_oh, w_oh, set_i, set_f, clr_i, clr_f;
  assign a_nz  = alloc_reg != '0;
  assign a_bad = alloc_valid & alloc_is_fp & alloc_dbl & (~a_nz | alloc_reg == TOP);
  assign a_oh  = N'(1) << alloc_reg;
  assign w_oh  = N'(1) << g_reg;
  assign set_i = (alloc_valid & ~alloc_is_fp & a_nz) ? a_oh : '0;
  assign set_f = (alloc_valid & alloc_is_fp & ~a_bad) ? (alloc_dbl ? a_oh | (a_oh << 1) : a_oh) : '0;
  assign clr_i = we_i_d ? w_oh : '0;
  assign clr_f = we_f_d ? w_oh : dwe_d ? w_oh | (w_oh << 1) : '0;
  logic              we_i_q, we_f_q, dwe_f_q, err_q;
  logic [AW-1:0]     waddr_i_q, waddr_f_q;
  logic [DATA_W-1:0] wdata_i_q, wdata1_q, wdata2_q;
  logic [N-1:0]      busy_i_q, busy_f_q;
  // Register the granted write, update busy bits (set beats clear), latch illegal writes
  always_ff @(posedge clk)
    if (reset) begin
      we_i_q    <= 1'b0;
      we_f_q    <= 1'b0;
      dwe_f_q   <= 1'b0;
      waddr_i_q <= '0;
      waddr_f_q <= '0;
      wdata_i_q <= '0;
      wdata1_q  <= '0;
      wdata2_q  <= '0;
      busy_i_q  <= '0;
      busy_f_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      we_i_q    <= we_i_d;
      we_f_q    <= we_f_d;
      dwe_f_q   <= dwe_d;
      waddr_i_q <= we_i_d ? g_reg : '0;
      wdata_i_q <= we_i_d ? g_lo : '0;
      waddr_f_q <= (we_f_d | dwe_d) ? g_reg : '0;
      wdata1_q  <= (we_f_d | dwe_d) ? g_lo : '0;
      wdata2_q  <= dwe_d ? g_hi : '0;
      busy_i_q  <= (busy_i_q & ~clr_i) | set_i;
      busy_f_q  <= (busy_f_q & ~clr_f) | set_f;
      err_q     <= err_q | bad_w | a_bad;
    end
  assign rf_we_i     = we_i_q;
  assign rf_waddr_i  = waddr_i_q;
  assign rf_wdata_i  = wdata_i_q;
  assign rf_we_f     = we_f_q;
  assign rf_dwe_f    = dwe_f_q;
  assign rf_waddr_f  = waddr_f_q;
  assign rf_wdata1_f = wdata1_q;
  assign rf_wdata2_f = wdata2_q;
  assign busy_i      = busy_i_q;
  assign busy_f      = busy_f_q;
  assign err_illegal = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] req_valid, req_ready, req_is_fp, req_dbl;
  logic [3*AW-1:0] req_reg;
  logic [3*DW-1:0] req_data_lo, req_data_hi;
  logic rf_we_i, rf_we_f, rf_dwe_f;
  logic [AW-1:0] rf_waddr_i, rf_waddr_f;
  logic [DW-1:0] rf_wdata_i, rf_wdata1_f, rf_wdata2_f;
  logic alloc_valid, alloc_is_fp, alloc_dbl;
  logic [AW-1:0] alloc_reg;
  logic [31:0] busy_i, busy_f;
  logic err_illegal;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.DATA_W(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_fp(req_is_fp), .req_dbl(req_dbl),
    .req_reg(req_reg), .req_data_lo(req_data_lo), .req_data_hi(req_data_hi),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
    .rf_we_f(rf_we_f), .rf_dwe_f(rf_dwe_f), .rf_waddr_f(rf_waddr_f),
    .rf_wdata1_f(rf_wdata1_f), .rf_wdata2_f(rf_wdata2_f),
    .alloc_valid(alloc_valid), .alloc_is_fp(alloc_is_fp), .alloc_dbl(alloc_dbl), .alloc_reg(alloc_reg),
    .busy_i(busy_i), .busy_f(busy_f), .err_illegal(err_illegal)
  );
  int m_ptr;
  logic [31:0] mb_i, mb_f;
  logic m_err, m_we_i, m_we_f, m_dwe;
  logic [AW-1:0] m_wa_i, m_wa_f;
  logic [DW-1:0] m_wd_i, m_wd1, m_wd2;
  function automatic int m_grant();
`ifdef WBARB_FIXED_PRIO_EN
    for (int k = 2; k >= 0; k--) if (req_valid[k]) return k;
`else
    for (int k = 0; k < 3; k++) if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`endif
    return -1;
  endfunction
  task automatic m_edge();
    int g, r, ar;
    logic fp, dbl;
    g = m_grant();
    m_we_i = 0; m_we_f = 0; m_dwe = 0;
    if (reset) begin
      m_ptr = 0; mb_i = 0; mb_f = 0; m_err = 0;
      return;
    end
    if (g >= 0) begin
      r = int'(req_reg[g*AW +: AW]); fp = req_is_fp[g]; dbl = req_dbl[g];
      if (!fp) begin
        if (r != 0) begin m_we_i = 1; m_wa_i = AW'(r); m_wd_i = req_data_lo[g*DW +: DW]; mb_i[r] = 0; end
      end else if (!dbl) begin
        if (r != 0) begin m_we_f = 1; m_wa_f = AW'(r); m_wd1 = req_data_lo[g*DW +: DW]; mb_f[r] = 0; end
      end else if (r == 0 || r == 31) m_err = 1;
      else begin
        m_dwe = 1; m_wa_f = AW'(r); m_wd1 = req_data_lo[g*DW +: DW]; m_wd2 = req_data_hi[g*DW +: DW];
        mb_f[r] = 0; mb_f[r+1] = 0;
      end
      m_ptr = (g + 1) % 3;
    end
    if (alloc_valid) begin
      ar = int'(alloc_reg);
      if (!alloc_is_fp) begin if (ar != 0) mb_i[ar] = 1; end
      else if (!alloc_dbl) mb_f[ar] = 1;
      else if (ar == 0 || ar == 31) m_err = 1;
      else begin mb_f[ar] = 1; mb_f[ar+1] = 1; end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask
  task automatic idle();
    reset = 0; req_valid = 0; req_is_fp = 0; req_dbl = 0; req_reg = 0;
    req_data_lo = 0; req_data_hi = 0;
    alloc_valid = 0; alloc_is_fp = 0; alloc_dbl = 0; alloc_reg = 0;
  endtask
  task automatic set_req(int p, logic fp, logic dbl, int r, logic [DW-1:0] lo, logic [DW-1:0] hi);
    req_valid[p] = 1; req_is_fp[p] = fp; req_dbl[p] = dbl; req_reg[p*AW +: AW] = AW'(r);
    req_data_lo[p*DW +: DW] = lo; req_data_hi[p*DW +: DW] = hi;
  endtask
  task automatic test_reset();
    idle(); reset = 1;
    tick(); tick();
    reset = 0;
    n_chk++;
    if ({rf_we_i, rf_we_f, rf_dwe_f, rf_waddr_i, rf_wdata_i, rf_waddr_f, rf_wdata1_f, rf_wdata2_f} !== '0) begin
      n_fail++; $display("FAIL reset_rf: got we=%b%b%b wa_i=%0d wa_f=%0d expected all zero", rf_we_i, rf_we_f, rf_dwe_f, rf_waddr_i, rf_waddr_f);
    end
    n_chk++;
    if ({busy_i, busy_f, err_illegal, req_ready} !== '0) begin
      n_fail++; $display("FAIL reset_busy: busy_i=%h busy_f=%h err=%b ready=%b expected zeros", busy_i, busy_f, err_illegal, req_ready);
    end
  endtask
  task automatic test_rr_int();
    logic [DW-1:0] d [3];
    idle();
    for (int p = 0; p < 3; p++) begin d[p] = $urandom; set_req(p, 0, 0, 3 + p, d[p], 0); end
    #1;
    for (int i = 0; i < 6; i++) begin
`ifdef WBARB_FIXED_PRIO_EN
      n_chk++;
      if (req_ready !== 3'b100) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected 100", i, req_ready); end
      tick(); #1;
      n_chk++;
      if (rf_we_i !== 1'b1 || rf_waddr_i !== 5'd5 || rf_wdata_i !== d[2]) begin
        n_fail++; $display("FAIL rr_write[%0d]: we=%b wa=%0d wd=%h expected 1/5/%h", i, rf_we_i, rf_waddr_i, rf_wdata_i, d[2]);
      end
`else
      n_chk++;
      if (req_ready !== 3'(1 << (i % 3))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, 3'(1 << (i % 3))); end
      tick(); #1;
      n_chk++;
      if (rf_we_i !== 1'b1 || rf_waddr_i !== AW'(3 + i % 3) || rf_wdata_i !== d[i % 3]) begin
        n_fail++; $display("FAIL rr_write[%0d]: we=%b wa=%0d wd=%h expected 1/%0d/%h", i, rf_we_i, rf_waddr_i, rf_wdata_i, 3 + i % 3, d[i % 3]);
      end
`endif
    end
    idle();
    tick();
  endtask
  task automatic test_fp_double();
    idle();
    alloc_valid = 1; alloc_is_fp = 1; alloc_dbl = 1; alloc_reg = 6;
    tick();
    n_chk++;
    if (busy_f[7:6] !== 2'b11) begin n_fail++; $display("FAIL dbl_alloc: busy_f[7:6]=%b expected 11", busy_f[7:6]); end
    idle();
    tick();
    n_chk++;
    if (busy_f[7:6] !== 2'b11) begin n_fail++; $display("FAIL dbl_hold: busy_f[7:6]=%b expected 11", busy_f[7:6]); end
    set_req(1, 1, 1, 6, 32'h11111111, 32'h22222222);
    #1;
    n_chk++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL dbl_ready: got %b expected 010", req_ready); end
    tick();
    idle();
    n_chk++;
    if ({rf_we_i, rf_we_f, rf_dwe_f} !== 3'b001 || rf_waddr_f !== 5'd6 || rf_wdata1_f !== 32'h11111111 || rf_wdata2_f !== 32'h22222222) begin
      n_fail++; $display("FAIL dbl_write: we=%b%b%b wa=%0d w1=%h w2=%h expected 001/6/11111111/22222222", rf_we_i, rf_we_f, rf_dwe_f, rf_waddr_f, rf_wdata1_f, rf_wdata2_f);
    end
    n_chk++;
    if (busy_f[7:6] !== 2'b00) begin n_fail++; $display("FAIL dbl_clear: busy_f[7:6]=%b expected 00", busy_f[7:6]); end
    tick();
    n_chk++;
    if (rf_dwe_f !== 1'b0) begin n_fail++; $display("FAIL dbl_oneshot: dwe=%b expected 0", rf_dwe_f); end
  endtask
  task automatic test_illegal();
    idle();
    set_req(0, 1, 1, 31, $urandom, $urandom);
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL ill_ready: got %b expected 001", req_ready); end
    tick();
    idle();
    n_chk++;
    if ({rf_we_i, rf_we_f, rf_dwe_f} !== 3'b000 || err_illegal !== 1'b1) begin
      n_fail++; $display("FAIL ill_write: we=%b%b%b err=%b expected 000 err=1", rf_we_i, rf_we_f, rf_dwe_f, err_illegal);
    end
    for (int i = 0; i < 4; i++) tick();
    n_chk++;
    if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: err=%b expected 1", err_illegal); end
  endtask
  task automatic test_alloc_clear_race();
    idle();
    alloc_valid = 1; alloc_reg = 9;
    set_req(2, 0, 0, 9, 32'hCAFE0009, 0);
    tick();
    idle();
    n_chk++;
    if (rf_we_i !== 1'b1 || rf_waddr_i !== 5'd9 || busy_i[9] !== 1'b1) begin
      n_fail++; $display("FAIL race: we=%b wa=%0d busy_i[9]=%b expected 1/9/1", rf_we_i, rf_waddr_i, busy_i[9]);
    end
    alloc_valid = 1; alloc_reg = 0;
    tick();
    idle();
    n_chk++;
    if (busy_i[0] !== 1'b0) begin n_fail++; $display("FAIL alloc_r0: busy_i[0]=%b expected 0", busy_i[0]); end
  endtask
  task automatic test_reset_mid();
    idle();
    set_req(1, 0, 0, 2, $urandom, 0);
    alloc_valid = 1; alloc_is_fp = 1; alloc_reg = 12;
    tick();
    idle();
    for (int p = 0; p < 3; p++) set_req(p, 0, 0, 10 + p, $urandom, 0);
    reset = 1;
    tick();
    reset = 0;
    n_chk++;
    if ({rf_we_i, rf_we_f, rf_dwe_f} !== 3'b000 || busy_i !== 0 || busy_f !== 0 || err_illegal !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: we=%b%b%b busy_i=%h busy_f=%h err=%b expected all 0", rf_we_i, rf_we_f, rf_dwe_f, busy_i, busy_f, err_illegal);
    end
    #1;
    n_chk++;
`ifdef WBARB_FIXED_PRIO_EN
    if (req_ready !== 3'b100) begin n_fail++; $display("FAIL rst_first: ready=%b expected 100", req_ready); end
`else
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_first: ready=%b expected 001", req_ready); end
`endif
    tick();
    idle();
    tick();
  endtask
  task automatic test_random();
    int g;
    logic [2:0] er;
    logic [3*AW+3*DW-1:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      req_valid = 3'($urandom); req_is_fp = 3'($urandom); req_dbl = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        req_reg[p*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1) * 31) : AW'($urandom);
        req_data_lo[p*DW +: DW] = $urandom; req_data_hi[p*DW +: DW] = $urandom;
      end
      alloc_valid = 1'($urandom); alloc_is_fp = 1'($urandom); alloc_dbl = ($urandom_range(0, 7) == 0);
      alloc_reg = AW'($urandom);
      #1;
      g = m_grant();
      er = (g < 0) ? 3'b000 : 3'(1 << g);
      n_chk++;
      if (req_ready !== er) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, req_ready, er); end
      tick();
      obs = {rf_waddr_i & {AW{m_we_i}}, rf_wdata_i & {DW{m_we_i}}, rf_waddr_f & {AW{m_we_f | m_dwe}},
             rf_wdata1_f & {DW{m_we_f | m_dwe}}, rf_wdata2_f & {DW{m_dwe}}};
      exp = {m_wa_i & {AW{m_we_i}}, m_wd_i & {DW{m_we_i}}, m_wa_f & {AW{m_we_f | m_dwe}},
             m_wd1 & {DW{m_we_f | m_dwe}}, m_wd2 & {DW{m_dwe}}};
      n_chk++;
      if ({rf_we_i, rf_we_f, rf_dwe_f} !== {m_we_i, m_we_f, m_dwe} || obs !== exp) begin
        n_fail++; $display("FAIL rnd_write[%0d]: we=%b%b%b wa_i=%0d wa_f=%0d expected we=%b%b%b wa_i=%0d wa_f=%0d", i,
          rf_we_i, rf_we_f, rf_dwe_f, rf_waddr_i, rf_waddr_f, m_we_i, m_we_f, m_dwe, m_wa_i, m_wa_f);
      end
      n_chk++;
      if (busy_i !== mb_i || busy_f !== mb_f || err_illegal !== m_err) begin
        n_fail++; $display("FAIL rnd_busy[%0d]: busy_i=%h busy_f=%h err=%b expected %h %h %b", i, busy_i, busy_f, err_illegal, mb_i, mb_f, m_err);
      end
    end
  endtask
  initial begin
    test_reset();
    test_rr_int();
    test_fp_double();
    test_illegal();
    test_alloc_clear_race();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
